instr_fetch_buffer: RTL and testbench

Instruction-fetch stage directly downstream of the program counter unit. Each cycle it accepts the current word-addressed PC, issues a read to instruction memory, and queues returned instructions in order with their PC. It presents them to decode with a valid/ready handshake. Alongside each instruction it provides the fields the PC unit consumes: opcode, sign-extended immediate and jump target. A flush input discards all queued and in-flight fetches on a redirect.

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/sync_fifo.sv | 63 ++++++
 rtl/instr_fetch_buffer.sv | 111 +++++++++++
 tb/tb_instr_fetch_buffer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU constants used by the fetch stage and its neighbours.
//   - opcode constants for the jump/branch instructions seen by the PC unit
//   - instruction field positions
//   - default instruction queue depth
//   - sign_ext16: sign-extends the immediate field of an instruction word
package cpu_pkg;

  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_JAL = 6'b000011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;

  localparam int OPC_MSB = 31;
  localparam int IMM_W   = 16;
  localparam int JIDX_W  = 26;

  localparam int DEF_DEPTH = 4;

  function automatic logic [31:0] sign_ext16(input logic [31:0] instr);
    return {{(32-IMM_W){instr[IMM_W-1]}}, instr[IMM_W-1:0]};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: registered circular FIFO with synchronous clear.
// Ports:
//   clock, reset_n      clock, asynchronous active-low reset
//   clear               drop all entries (wins over push/pop)
//   push, din           write din at tail (allowed when full if popping)
//   pop                 remove head (ignored when empty)
//   dout                head entry (undefined when empty)
//   full, empty, count  occupancy status
module sync_fifo #(
  parameter int W  = 32,
  parameter int D  = 4,
  parameter int CW = $clog2(D+1)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          clear,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  localparam int PW = (D > 1) ? $clog2(D) : 1;

  logic [W-1:0]  mem [D];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(D-1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(D));
  assign do_pop  = pop & ~empty;
  // A push on a full FIFO is fine when the head leaves the same cycle.
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= nxt(wr_ptr);
      if (do_pop)  rd_ptr <= nxt(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage carries no reset; consumers gate dout with empty.
  always_ff @(posedge clock) begin
    if (do_push && !clear) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/instr_fetch_buffer.sv
// instr_fetch_buffer: fetch stage between the PC unit and decode.
// Accepts a PC per cycle, reads imem, queues {pc, instr} in order and
// presents the head to decode with decoded opcode / immediate / jump target.
// Ports:
//   clock, reset_n                  clock, asynchronous active-low reset
//   pc_in, pc_valid, pc_ready       PC handshake from the PC unit
//   flush                           redirect: drop queued and in-flight fetches
//   imem_req, imem_addr, imem_gnt   read request channel
//   imem_rvalid, imem_rdata         in-order read response
//   id_valid, id_ready              head handshake to decode
//   id_instr, id_pc                 head entry (zero when queue empty)
//   id_opcode, id_sign_ext, id_target  fields derived from the head
module instr_fetch_buffer
  import cpu_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = 32
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic [AW-1:0] pc_in,
  input  logic          pc_valid,
  output logic          pc_ready,
  input  logic          flush,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_gnt,
  input  logic          imem_rvalid,
  input  logic [31:0]   imem_rdata,
  output logic          id_valid,
  input  logic          id_ready,
  output logic [31:0]   id_instr,
  output logic [AW-1:0] id_pc,
  output logic [5:0]    id_opcode,
  output logic [31:0]   id_sign_ext,
  output logic [AW-1:0] id_target
);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic RUN   = 1'b0;
  localparam logic DRAIN = 1'b1;

  logic          state;
  logic [CW-1:0] outst, drop, occ, tag_cnt;
  logic          credit, rsp_take, q_empty;
  logic [CW:0]   pending, drop_flush;
  logic [AW-1:0] tag_pc;
  logic [AW+31:0] q_head;
  logic          unused_sigs;

  assign credit   = ({1'b0, occ} + {1'b0, outst}) < (CW+1)'(DEPTH);
  // reset_n gates the request so nothing is issued while reset is held.
  assign imem_req  = reset_n & (state == RUN) & pc_valid & credit & ~flush;
  assign imem_addr = pc_in;
  assign pc_ready  = imem_req & imem_gnt;

  // Responses are queued only in RUN outside a flush; drained or stray
  // responses never reach the queue.
  assign rsp_take = imem_rvalid & (state == RUN) & (outst != '0) & ~flush;

  // Responses still owed after a flush: drop is only non-zero in DRAIN,
  // where outst is zero, so the sum covers a flush in either state.
  assign pending    = {1'b0, outst} + {1'b0, drop};
  assign drop_flush = pending - (CW+1)'(imem_rvalid && pending != '0);

  sync_fifo #(.W(AW), .D(DEPTH)) u_tag_fifo (
    .clock(clock), .reset_n(reset_n), .clear(flush),
    .push(pc_ready), .pop(rsp_take), .din(pc_in),
    .dout(tag_pc), .full(), .empty(), .count(tag_cnt)
  );

  sync_fifo #(.W(AW+32), .D(DEPTH)) u_instr_q (
    .clock(clock), .reset_n(reset_n), .clear(flush),
    .push(rsp_take), .pop(id_valid & id_ready), .din({tag_pc, imem_rdata}),
    .dout(q_head), .full(), .empty(q_empty), .count(occ)
  );

  assign unused_sigs = ^tag_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= RUN;
      outst <= '0;
      drop  <= '0;
    end else if (flush) begin
      outst <= '0;
      drop  <= drop_flush[CW-1:0];
      state <= (drop_flush != '0) ? DRAIN : RUN;
    end else if (state == DRAIN) begin
      if (imem_rvalid && drop != '0) begin
        drop <= drop - 1'b1;
        if (drop == CW'(1)) state <= RUN;
      end
    end else begin
      outst <= outst + CW'(pc_ready) - CW'(rsp_take);
    end
  end

  assign id_valid    = ~q_empty;
  assign id_instr    = q_empty ? '0 : q_head[31:0];
  assign id_pc       = q_empty ? '0 : q_head[AW+31:32];
  assign id_opcode   = id_instr[OPC_MSB -: 6];
  assign id_sign_ext = sign_ext16(id_instr);
  assign id_target   = {id_pc[AW-1:JIDX_W], id_instr[JIDX_W-1:0]};

  // A response with nothing outstanding and nothing to drop is a memory
  // protocol violation; it is ignored above.
  always @(posedge clock) begin
    if (reset_n) assert (!(imem_rvalid && outst == '0 && drop == '0));
  end

endmodule

// File: tb/tb_instr_fetch_buffer.sv
module tb_instr_fetch_buffer;
  import cpu_pkg::*;
  localparam int DEPTH = 4;
  localparam int AW    = 32;

  logic clock = 1'b0, reset_n = 1'b0;
  logic [AW-1:0] pc_in = '0;
  logic pc_valid = 1'b0, flush = 1'b0, imem_gnt = 1'b0, imem_rvalid = 1'b0, id_ready = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic imem_req, pc_ready, id_valid;
  logic [AW-1:0] imem_addr, id_pc, id_target;
  logic [31:0] id_instr, id_sign_ext;
  logic [5:0] id_opcode;

  always #5 clock = ~clock;

  instr_fetch_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clock(clock), .reset_n(reset_n), .pc_in(pc_in), .pc_valid(pc_valid),
    .pc_ready(pc_ready), .flush(flush), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc),
    .id_opcode(id_opcode), .id_sign_ext(id_sign_ext), .id_target(id_target)
  );

  int n_tests = 0, n_fail = 0, cyc = 0;

  typedef struct {logic [31:0] addr; logic [31:0] data; int due;} mreq_t;
  typedef struct {logic [31:0] pc; logic [31:0] instr;} ent_t;
  mreq_t       memq[$];   // requests granted by memory, not yet answered
  ent_t        mq[$];     // reference instruction queue
  logic [31:0] tags[$];   // PCs whose data is still owed and will be kept
  int          mdrop = 0; // responses owed that will be thrown away

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    if (a == 32'h10) return 32'h1000FFFC;
    if (a == 32'h11) return 32'h08000123;
    return $urandom;
  endfunction

  // One clock cycle: drive inputs, check outputs against the model, advance model.
  task automatic step(input bit pv, input logic [31:0] pc, input bit g, input bit fl,
                      input bit rdy, input int rv_pct, input int lat);
    bit rv, e_req, e_rdy, e_val;
    logic [31:0] rd, tpc;
    ent_t h;
    @(negedge clock);
    rv = memq.size() > 0 && memq[0].due <= cyc && ($urandom_range(99) < rv_pct);
    rd = rv ? memq[0].data : $urandom;
    pc_valid = pv; pc_in = pc; imem_gnt = g; flush = fl; id_ready = rdy;
    imem_rvalid = rv; imem_rdata = rd;
    #1;
    e_req = reset_n && pv && mdrop == 0 && (mq.size() + tags.size() < DEPTH) && !fl;
    e_rdy = e_req && g;
    e_val = mq.size() > 0;
    h = e_val ? mq[0] : '{32'h0, 32'h0};
    chk("imem_req", 32'(imem_req), 32'(e_req));
    chk("pc_ready", 32'(pc_ready), 32'(e_rdy));
    chk("imem_addr", imem_addr, pc);
    chk("id_valid", 32'(id_valid), 32'(e_val));
    chk("id_instr", id_instr, h.instr);
    chk("id_pc", id_pc, h.pc);
    chk("id_opcode", 32'(id_opcode), h.instr >> 26);
    chk("id_sign_ext", id_sign_ext, 32'($signed(h.instr[15:0])));
    chk("id_target", id_target, (h.pc & 32'hFC00_0000) | (h.instr & 32'h03FF_FFFF));
    if (rv) void'(memq.pop_front());
    if (e_rdy) memq.push_back('{pc, mem_data(pc), cyc + lat});
    if (fl) begin
      int p;
      p = tags.size() + mdrop;
      if (rv && p > 0) p--;
      mdrop = p;
      tags.delete();
      mq.delete();
    end else begin
      if (e_val && rdy) void'(mq.pop_front());
      if (rv) begin
        if (mdrop > 0) mdrop--;
        else if (tags.size() > 0) begin
          tpc = tags.pop_front();
          mq.push_back('{tpc, rd});
        end
      end
      if (e_rdy) tags.push_back(pc);
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 32'h0, 0, 0, 1, 100, 1);
  endtask

  initial begin
    int g, g2;
    bit seen;
    logic [31:0] first_pc;

    // reset: requests suppressed even with pc_valid/gnt high
    pc_valid = 1'b1; imem_gnt = 1'b1;
    repeat (2) @(negedge clock);
    #1;
    chk("rst_req", 32'(imem_req), 32'h0);
    chk("rst_pc_ready", 32'(pc_ready), 32'h0);
    chk("rst_id_valid", 32'(id_valid), 32'h0);
    chk("rst_id_pc", id_pc, 32'h0);
    pc_valid = 1'b0; imem_gnt = 1'b0;
    @(negedge clock) reset_n = 1'b1;

    // streaming: one instruction per cycle, two cycles of latency
    for (int k = 0; k < 16; k++) begin
      step(1, 32'(k), 1, 0, 1, 100, 1);
      chk("stream_v", 32'(id_valid), 32'(k >= 2));
      if (k >= 2) chk("stream_pc", id_pc, 32'(k - 2));
    end

    // reset pulsed mid-stream: outputs clear within the cycle
    for (int k = 16; k < 19; k++) step(1, 32'(k), 1, 0, 0, 100, 1);
    @(negedge clock);
    pc_valid = 1'b1; pc_in = 32'h99; imem_gnt = 1'b1; imem_rvalid = 1'b0; flush = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    chk("mid_rst_req", 32'(imem_req), 32'h0);
    chk("mid_rst_pc_ready", 32'(pc_ready), 32'h0);
    chk("mid_rst_id_valid", 32'(id_valid), 32'h0);
    chk("mid_rst_id_instr", id_instr, 32'h0);
    chk("mid_rst_id_pc", id_pc, 32'h0);
    chk("mid_rst_id_sext", id_sign_ext, 32'h0);
    mq.delete(); tags.delete(); memq.delete(); mdrop = 0;
    repeat (2) @(negedge clock);
    pc_valid = 1'b0; imem_gnt = 1'b0;
    reset_n = 1'b1;

    // backpressure: four grants, then closed; one pop reopens one slot
    idle(3);
    g = 0;
    for (int i = 0; i < 8; i++) begin
      step(1, 32'h100 + 32'(g), 1, 0, 0, 100, 1);
      if (pc_ready) g++;
    end
    chk("bp_grants", 32'(g), 32'd4);
    chk("bp_req_closed", 32'(imem_req), 32'h0);
    step(1, 32'h100 + 32'(g), 1, 0, 1, 100, 1);
    chk("bp_pop_cycle_ready", 32'(pc_ready), 32'h0);
    g2 = 0;
    for (int i = 0; i < 3; i++) begin
      step(1, 32'h100 + 32'(g + g2), 1, 0, 0, 100, 1);
      if (pc_ready) g2++;
    end
    chk("bp_reopen", 32'(g2), 32'd1);

    // flush with one queued and two outstanding
    idle(8);
    step(1, 32'h20, 1, 0, 0, 100, 1);
    step(1, 32'h21, 1, 0, 0, 100, 6);
    step(1, 32'h22, 1, 0, 0, 100, 6);
    step(1, 32'h23, 1, 1, 0, 100, 1);
    chk("flush_pc_ready", 32'(pc_ready), 32'h0);
    step(0, 32'h0, 0, 0, 0, 100, 1);
    chk("flush_empty", 32'(id_valid), 32'h0);
    seen = 0; first_pc = 32'hDEAD_BEEF; g = 0;
    for (int i = 0; i < 14; i++) begin
      step(g == 0, 32'h40, 1, 0, 1, 100, 1);
      if (pc_ready) g = 1;
      if (id_valid && !seen) begin seen = 1; first_pc = id_pc; end
    end
    chk("post_flush_pc", first_pc, 32'h40);

    // flush coincident with the only outstanding response: no drain
    idle(6);
    step(1, 32'h30, 1, 0, 0, 100, 1);
    step(1, 32'h31, 1, 0, 0, 100, 1);
    step(0, 32'h0, 0, 1, 0, 100, 1);
    step(1, 32'h50, 1, 0, 0, 100, 1);
    chk("flush_rv_no_drain", 32'(pc_ready), 32'h1);

    // field extraction
    idle(6);
    step(1, 32'h10, 1, 0, 0, 100, 1);
    step(1, 32'h11, 1, 0, 0, 100, 1);
    step(0, 32'h0, 0, 0, 0, 100, 1);
    chk("fld_opcode", 32'(id_opcode), 32'(OP_BEQ));
    chk("fld_sext", id_sign_ext, 32'hFFFF_FFFC);
    step(0, 32'h0, 0, 0, 1, 100, 1);
    step(0, 32'h0, 0, 0, 0, 100, 1);
    chk("fld_jopc", 32'(id_opcode), 32'(OP_J));
    chk("fld_target", id_target, 32'h0000_0123);

    // randomized traffic
    idle(6);
    for (int i = 0; i < 1500; i++)
      step($urandom_range(9) < 7, $urandom, $urandom_range(9) < 7, $urandom_range(99) < 4,
           $urandom_range(9) < 6, 70, $urandom_range(4, 1));
    idle(12);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
